// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code decoder with succession check, lock FSM and error counter
module johnson_decoder #(
    parameter int N        = 5,
    parameter int IDX_W    = 4,
    parameter int LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     code_in,
    input  logic             code_valid,
    input  logic             clear_err,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             wrap,
    output logic             locked,
    output logic [7:0]       err_count
);

    localparam logic [N-1:0]     ONES     = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N - 1);
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    logic [IDX_W-1:0] index_q, ref_idx_q;
    logic             index_valid_q, illegal_q, seq_err_q, wrap_q, ref_ok_q, locked_q;
    logic [7:0]       err_count_q;
    logic [3:0]       good_cnt_q;
    lock_state_t      state_q;

    logic             code_legal;
    logic [IDX_W-1:0] code_idx;
    logic [IDX_W-1:0] exp_idx;
    logic             mismatch;
    logic             good_step;
    logic             bad_sample;
    logic [3:0]       good_inc;

    // Decode: ones filled from the MSB give index k, ones filled from the LSB give 2N-m
    always_comb begin
        code_legal = 1'b0;
        code_idx   = '0;
        for (int k = 0; k <= N; k++) begin
            if (code_in == ~(ONES >> k)) begin
                code_legal = 1'b1;
                code_idx   = IDX_W'(k);
            end
        end
        for (int m = 1; m < N; m++) begin
            if (code_in == (ONES >> (N - m))) begin
                code_legal = 1'b1;
                code_idx   = IDX_W'(2 * N - m);
            end
        end
    end

    // Succession qualifiers for the current sample against the stored reference
    always_comb begin
        exp_idx    = (ref_idx_q == LAST_IDX) ? '0 : ref_idx_q + 1'b1;
        mismatch   = ref_ok_q && (code_idx != exp_idx);
        good_step  = code_valid && code_legal && ref_ok_q && !mismatch;
        bad_sample = code_valid && (!code_legal || mismatch);
        good_inc   = good_cnt_q + 4'd1;
    end

    // Sample datapath: decoded index, status flags, reference and error counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_q       <= '0;
            index_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            wrap_q        <= 1'b0;
            ref_ok_q      <= 1'b0;
            ref_idx_q     <= '0;
            err_count_q   <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (code_valid) begin
                if (code_legal) begin
                    index_q       <= code_idx;
                    index_valid_q <= 1'b1;
                    illegal_q     <= 1'b0;
                    seq_err_q     <= mismatch;
                    wrap_q        <= good_step && (code_idx == '0);
                    ref_ok_q      <= 1'b1;
                    ref_idx_q     <= code_idx;
                end else begin
                    index_valid_q <= 1'b0;
                    illegal_q     <= 1'b1;
                    seq_err_q     <= 1'b0;
                    ref_ok_q      <= 1'b0;
                end
            end
            if (clear_err) begin
                err_count_q <= bad_sample ? 8'd1 : 8'd0;
            end else if (bad_sample && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // Lock FSM: count consecutive correct successions, drop lock on the first error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                UNLOCKED: begin
                    if (bad_sample) begin
                        good_cnt_q <= '0;
                    end else if (good_step) begin
                        if (good_inc == LOCK_TGT) begin
                            state_q    <= LOCKED;
                            locked_q   <= 1'b1;
                            good_cnt_q <= '0;
                        end else begin
                            good_cnt_q <= good_inc;
                        end
                    end
                end
                LOCKED: begin
                    if (bad_sample) begin
                        state_q    <= UNLOCKED;
                        locked_q   <= 1'b0;
                        good_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= UNLOCKED;
                    locked_q   <= 1'b0;
                    good_cnt_q <= '0;
                end
            endcase
        end
    end

    assign index       = index_q;
    assign index_valid = index_valid_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_err_q;
    assign wrap        = wrap_q;
    assign locked      = locked_q;
    assign err_count   = err_count_q;

endmodule
